dnn_dense_layer_fix: RTL and testbench
======================================

# dnn_dense_layer_fix

Parametrised fixed-point fully-connected layer engine for the MNIST inference datapath. On `start` it fetches N_IN activations from a single-port synchronous memory into a local buffer, then streams each neuron's weight row, accumulates, scales, optionally applies ReLU, saturates, and registers N_OUT results plus their argmax. It generalises the fixed 7-bit ReLU network wrapper to arbitrary width, fan-in, fan-out, bias and activation mode, and can be chained per layer under a top-level sequencer.

## Interface
- DATA_WIDTH, 7, signed activation/weight/output width
- ADDR_WIDTH, 16, memory address width
- N_IN, 16, inputs per neuron (>=1)
- N_OUT, 10, neurons (>=1)
- ACC_WIDTH, 24, accumulator width; must be >= 2*DATA_WIDTH + clog2(N_IN+1)
- ADDR_BASE_A, 16'h0000, address of activation a[0]
- ADDR_BASE_W, 16'h0191, address of W[0][0]
- SHIFT, 4, arithmetic right shift applied to the accumulator
- RELU_EN, 1, 1 = clamp negative results to 0
- BIAS_EN, 1, 1 = each row carries one extra bias weight
- BIAS_VAL, 7'b0100000, constant multiplied with the bias weight
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse, begins a run when idle
- reset  in  1  synchronous soft clear, same effect as rst at next edge
- mem_data  in  DATA_WIDTH  signed read data, valid one cycle after mem_addr
- mem_addr  out  ADDR_WIDTH  registered read address
- busy  out  1  high from the cycle after accepted start until done
- done  out  1  level, high when results valid; held until next accepted start, reset or rst
- out  out  DATA_WIDTH x N_OUT  signed results, out[j] for neuron j
- argmax  out  clog2(N_OUT)  index of largest out[j]

## Operation
- Memory map: a[i] at ADDR_BASE_A+i; W[j][i] at ADDR_BASE_W + j*K + i with K = N_IN+BIAS_EN; bias weight at i = N_IN.
- States: IDLE, LOAD, MAC, FIN, DONE. DONE behaves as IDLE for start acceptance.
- IDLE/DONE -> LOAD on start (reset low). LOAD issues N_IN addresses on consecutive cycles and captures each mem_data one cycle later into buffer; lasts N_IN+1 cycles.
- MAC, per neuron j: issues K weight addresses, accumulator cleared at entry, acc += w*a[i] (or w*BIAS_VAL for bias term); lasts K+1 cycles.
- FIN, 1 cycle: r = acc >>> SHIFT (floor); if RELU_EN and r<0 then r=0; saturate to [-2^(DW-1), 2^(DW-1)-1]; write out[j]; update argmax. Then MAC for j+1, or DONE after j = N_OUT-1.
- Products are 2*DATA_WIDTH signed, sign-extended into ACC_WIDTH; accumulator wraps, no overflow flag.
- Argmax compares saturated values, strictly greater replaces; ties keep the lowest index.
- start while busy ignored. reset/rst dominate start in the same cycle.
- Reset values (rst or reset): state IDLE, busy 0, done 0, out all 0, argmax 0, mem_addr ADDR_BASE_A, buffer contents don't-care.
- On accepted start, done drops and out/argmax are cleared; out[j] is updated only in its FIN cycle.

## Timing
- start sampled high at edge 0; busy high from cycle 1.
- done rises N_IN + 2 + N_OUT*(K+2) cycles after the start edge; busy falls the same cycle. Defaults: 16+2+10*19 = 208.
- mem_addr changes at most once per cycle; with one-cycle read latency, data from mem_addr in cycle t is used at edge t+1.
- Throughput: one MAC per cycle during MAC; no overlap between runs.
- rst mid-run: immediate return to reset values; reset mid-run: the same at the next edge; a later start runs a full fresh pass.

## Test plan
- Defaults, all a=1, all W=1, bias weights 0 -> every out=1 (16>>>4), argmax 0, done exactly 208 cycles after start.
- a=63, W=63, RELU_EN=1 -> every out=63 (saturated); W=-63 -> every out=0; with RELU_EN=0 -> every out=-64.
- RELU_EN=0, single nonzero product -1 -> out=-1 (floor shift); bias only (a=0, bias W=2, BIAS_VAL=32) -> out=4.
- Row 3 and row 7 both produce 20, others 5 -> argmax 3; all zero after ReLU -> argmax 0.
- reset pulsed during neuron 4 MAC -> next edge busy/done 0, out all 0; new start then completes in 208 cycles with correct results.
- start pulsed while busy -> ignored, done timing unchanged; start in DONE -> done drops next cycle, second run reproduces results.

Source files
------------

// File: rtl/dnn_dense_layer_fix.sv
// Fixed-point fully-connected layer engine: loads N_IN activations from a
// single-port synchronous memory, then for each neuron streams its weight row,
// multiply-accumulates, scales, optionally applies ReLU, saturates and tracks argmax.
module dnn_dense_layer_fix #(
    parameter int                    DATA_WIDTH  = 7,
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    N_IN        = 16,
    parameter int                    N_OUT       = 10,
    parameter int                    ACC_WIDTH   = 24,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_A = 16'h0000,
    parameter logic [ADDR_WIDTH-1:0] ADDR_BASE_W = 16'h0191,
    parameter int                    SHIFT       = 4,
    parameter int                    RELU_EN     = 1,
    parameter int                    BIAS_EN     = 1,
    parameter logic [DATA_WIDTH-1:0] BIAS_VAL    = 7'b0100000,
    localparam int                   AM_W        = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        reset,
    input  logic [DATA_WIDTH-1:0]       mem_data,
    output logic [ADDR_WIDTH-1:0]       mem_addr,
    output logic                        busy,
    output logic                        done,
    output logic [N_OUT*DATA_WIDTH-1:0] out,
    output logic [AM_W-1:0]             argmax
);

    localparam int K  = N_IN + BIAS_EN;
    localparam int IW = $clog2(K + 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_MAC  = 3'd2;
    localparam logic [2:0] S_FIN  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    localparam logic signed [ACC_WIDTH-1:0] MAXV = ACC_WIDTH'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [ACC_WIDTH-1:0] MINV = ~MAXV;

    logic [2:0]                   r_state;
    logic                         r_a_vld;   // an address is on mem_addr this cycle
    logic [IW-1:0]                r_a_idx;
    logic                         r_d_vld;   // mem_data holds the word addressed last cycle
    logic [IW-1:0]                r_d_idx;
    logic [DATA_WIDTH-1:0]        r_buf [N_IN];
    logic signed [ACC_WIDTH-1:0]  r_acc;
    logic [AM_W-1:0]              r_j;
    logic [ADDR_WIDTH-1:0]        r_wbase;
    logic [ADDR_WIDTH-1:0]        r_addr;
    logic signed [DATA_WIDTH-1:0] r_out [N_OUT];
    logic signed [DATA_WIDTH-1:0] r_best;
    logic [AM_W-1:0]              r_argmax;
    logic                         r_busy;
    logic                         r_done;

    logic [DATA_WIDTH-1:0]          w_term;
    logic signed [2*DATA_WIDTH-1:0] w_prod;
    logic signed [ACC_WIDTH-1:0]    w_prod_ext;
    logic signed [ACC_WIDTH-1:0]    w_shift;
    logic signed [ACC_WIDTH-1:0]    w_relu;
    logic signed [DATA_WIDTH-1:0]   w_sat;

    // Select the multiplicand: buffered activation, or the bias constant past the last input.
    always_comb begin
        w_term = BIAS_VAL;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (r_d_idx == IW'(i)) w_term = r_buf[i];
        end
    end

    assign w_prod     = $signed(mem_data) * $signed(w_term);
    assign w_prod_ext = {{(ACC_WIDTH - 2*DATA_WIDTH){w_prod[2*DATA_WIDTH-1]}}, w_prod};
    assign w_shift    = r_acc >>> SHIFT;
    assign w_relu     = ((RELU_EN != 0) && w_shift[ACC_WIDTH-1]) ? '0 : w_shift;

    // Saturate the scaled accumulator to the signed output range.
    always_comb begin
        if (w_relu > MAXV)      w_sat = MAXV[DATA_WIDTH-1:0];
        else if (w_relu < MINV) w_sat = MINV[DATA_WIDTH-1:0];
        else                    w_sat = w_relu[DATA_WIDTH-1:0];
    end

    // Capture activations into the local buffer as they return from memory.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && r_d_vld) begin
            for (int unsigned i = 0; i < N_IN; i++) begin
                if (r_d_idx == IW'(i)) r_buf[i] <= mem_data;
            end
        end
    end

    // Sequencer: address generation, accumulation, scaling and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_a_vld  <= 1'b0;
            r_a_idx  <= '0;
            r_d_vld  <= 1'b0;
            r_d_idx  <= '0;
            r_acc    <= '0;
            r_j      <= '0;
            r_wbase  <= ADDR_BASE_W;
            r_addr   <= ADDR_BASE_A;
            r_best   <= '0;
            r_argmax <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int unsigned j = 0; j < N_OUT; j++) r_out[j] <= '0;
        end else if (reset) begin
            r_state  <= S_IDLE;
            r_a_vld  <= 1'b0;
            r_a_idx  <= '0;
            r_d_vld  <= 1'b0;
            r_d_idx  <= '0;
            r_acc    <= '0;
            r_j      <= '0;
            r_wbase  <= ADDR_BASE_W;
            r_addr   <= ADDR_BASE_A;
            r_best   <= '0;
            r_argmax <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            for (int unsigned j = 0; j < N_OUT; j++) r_out[j] <= '0;
        end else begin
            // Read data trails its address by one cycle.
            r_d_vld <= r_a_vld;
            r_d_idx <= r_a_idx;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state  <= S_LOAD;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                        r_best   <= '0;
                        r_argmax <= '0;
                        r_addr   <= ADDR_BASE_A;
                        r_wbase  <= ADDR_BASE_W;
                        r_a_vld  <= 1'b1;
                        r_a_idx  <= '0;
                        r_d_vld  <= 1'b0;
                        r_j      <= '0;
                        for (int unsigned j = 0; j < N_OUT; j++) r_out[j] <= '0;
                    end
                end
                S_LOAD: begin
                    if (r_a_vld) begin
                        if (r_a_idx == IW'(N_IN - 1)) begin
                            r_a_vld <= 1'b0;
                        end else begin
                            r_a_idx <= r_a_idx + IW'(1);
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                    if (r_d_vld && r_d_idx == IW'(N_IN - 1)) begin
                        r_state <= S_MAC;
                        r_addr  <= r_wbase;
                        r_a_vld <= 1'b1;
                        r_a_idx <= '0;
                        r_d_vld <= 1'b0;
                        r_acc   <= '0;
                    end
                end
                S_MAC: begin
                    if (r_a_vld) begin
                        if (r_a_idx == IW'(K - 1)) begin
                            r_a_vld <= 1'b0;
                        end else begin
                            r_a_idx <= r_a_idx + IW'(1);
                            r_addr  <= r_addr + ADDR_WIDTH'(1);
                        end
                    end
                    if (r_d_vld) begin
                        r_acc <= r_acc + w_prod_ext;
                        if (r_d_idx == IW'(K - 1)) r_state <= S_FIN;
                    end
                end
                S_FIN: begin
                    for (int unsigned j = 0; j < N_OUT; j++) begin
                        if (r_j == AM_W'(j)) r_out[j] <= w_sat;
                    end
                    // Strictly greater replaces, so ties keep the lowest index.
                    if (r_j == '0 || w_sat > r_best) begin
                        r_best   <= w_sat;
                        r_argmax <= r_j;
                    end
                    if (r_j == AM_W'(N_OUT - 1)) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_MAC;
                        r_j     <= r_j + AM_W'(1);
                        r_wbase <= r_wbase + ADDR_WIDTH'(K);
                        r_addr  <= r_wbase + ADDR_WIDTH'(K);
                        r_a_vld <= 1'b1;
                        r_a_idx <= '0;
                        r_d_vld <= 1'b0;
                        r_acc   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Flatten result registers onto the output bus, neuron j at bits [j*DW +: DW].
    always_comb begin
        out = '0;
        for (int unsigned j = 0; j < N_OUT; j++) begin
            out[j*DATA_WIDTH +: DATA_WIDTH] = r_out[j];
        end
    end

    assign mem_addr = r_addr;
    assign busy     = r_busy;
    assign done     = r_done;
    assign argmax   = r_argmax;

endmodule

// File: tb/tb_dnn_dense_layer_fix.sv
// Scoreboard bench for dnn_dense_layer_fix: a ReLU instance and a no-ReLU instance
// share one memory model; expected results are queued per run and checked when done rises.
module tb_dnn_dense_layer_fix;

    localparam int NI = 16;
    localparam int NO = 10;
    localparam int K  = 17;
    localparam int WB = 16'h0191;

    logic        clk = 1'b0;
    logic        rst, start, reset;
    logic [6:0]  md_a, md_b;
    logic [15:0] ma_a, ma_b;
    logic        busy_a, busy_b, done_a, done_b;
    logic [69:0] out_a, out_b;
    logic [3:0]  am_a, am_b;

    logic signed [6:0] mem [0:1023];

    typedef struct {
        int o[NO];
        int am;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t ea, eb;
    int   n_vec = 0;
    int   n_err = 0;
    logic pa = 1'b0;
    logic pb = 1'b0;

    dnn_dense_layer_fix u_dut_a (
        .clk(clk), .rst(rst), .start(start), .reset(reset),
        .mem_data(md_a), .mem_addr(ma_a), .busy(busy_a), .done(done_a),
        .out(out_a), .argmax(am_a)
    );

    dnn_dense_layer_fix #(.RELU_EN(0)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .reset(reset),
        .mem_data(md_b), .mem_addr(ma_b), .busy(busy_b), .done(done_b),
        .out(out_b), .argmax(am_b)
    );

    always #5 clk = ~clk;

    // Synchronous single-cycle-latency memory, one read port per instance.
    always @(posedge clk) begin
        md_a <= mem[ma_a[9:0]];
        md_b <= mem[ma_b[9:0]];
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic signed [31:0] outj(input logic [69:0] v, input int j);
        logic signed [6:0] t;
        t = v[j*7 +: 7];
        return 32'(t);
    endfunction

    // Monitor: on each rising done, pop the expected record and compare every output.
    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1 && pa !== 1'b1) begin
            if (q_a.size() == 0) chk("sb_a_unexpected", 1, 0);
            else begin
                e = q_a.pop_front();
                for (int j = 0; j < NO; j++) chk($sformatf("a_out%0d", j), outj(out_a, j), e.o[j]);
                chk("a_argmax", 32'(am_a), e.am);
            end
        end
        if (done_b === 1'b1 && pb !== 1'b1) begin
            if (q_b.size() == 0) chk("sb_b_unexpected", 1, 0);
            else begin
                e = q_b.pop_front();
                for (int j = 0; j < NO; j++) chk($sformatf("b_out%0d", j), outj(out_b, j), e.o[j]);
                chk("b_argmax", 32'(am_b), e.am);
            end
        end
        pa = done_a;
        pb = done_b;
    end

    task automatic fill(input int av, input int wv, input int bv);
        for (int i = 0; i < NI; i++) mem[i] = 7'(av);
        for (int j = 0; j < NO; j++) begin
            for (int i = 0; i < NI; i++) mem[WB + j*K + i] = 7'(wv);
            mem[WB + j*K + NI] = 7'(bv);
        end
    endtask

    task automatic exp_all(input int va, input int vb, input int ama, input int amb);
        for (int j = 0; j < NO; j++) begin
            ea.o[j] = va;
            eb.o[j] = vb;
        end
        ea.am = ama;
        eb.am = amb;
    endtask

    // Issue one full run; optionally pulse start mid-run, which must be ignored.
    task automatic run(input bit poke);
        int cyc;
        q_a.push_back(ea);
        q_b.push_back(eb);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        chk("busy_cycle1", 32'(busy_a), 1);
        chk("done_dropped", 32'(done_a), 0);
        chk("out_cleared", 32'(out_a == '0 && am_a == '0), 1);
        while (done_a !== 1'b1 && cyc < 400) begin
            @(posedge clk);
            #1 cyc++;
            if (poke) start = (cyc == 60);
        end
        start = 1'b0;
        chk("done_latency", cyc, 208);
        chk("done_b_aligned", 32'(done_b), 1);
        chk("busy_fell", 32'(busy_a), 0);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        reset = 1'b0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_done", 32'(done_a), 0);
        chk("rst_out", 32'(out_a == '0), 1);
        chk("rst_argmax", 32'(am_a), 0);
        chk("rst_addr", 32'(ma_a), 0);

        // All ones, zero bias: 16 >>> 4 = 1.
        fill(1, 1, 0);
        exp_all(1, 1, 0, 0);
        run(0);

        // Positive saturation, with an ignored start while busy.
        fill(63, 63, 0);
        exp_all(63, 63, 0, 0);
        run(1);

        // Large negative: ReLU clamps to 0, otherwise saturates to -64.
        fill(63, -63, 0);
        exp_all(0, -64, 0, 0);
        run(0);

        // Single product of -1: floor shift gives -1.
        fill(0, 0, 0);
        mem[0] = 7'sd1;
        for (int j = 0; j < NO; j++) mem[WB + j*K] = -7'sd1;
        exp_all(0, -1, 0, 0);
        run(0);

        // Bias only: 2 * 32 = 64 -> 4.
        fill(0, 0, 2);
        exp_all(4, 4, 0, 0);
        run(0);

        // Rows 3 and 7 tie at 20, others 5: lowest index wins.
        fill(1, 5, 0);
        for (int i = 0; i < NI; i++) begin
            mem[WB + 3*K + i] = 7'sd20;
            mem[WB + 7*K + i] = 7'sd20;
        end
        exp_all(5, 5, 3, 3);
        ea.o[3] = 20; ea.o[7] = 20;
        eb.o[3] = 20; eb.o[7] = 20;
        run(0);

        // Per-row weights j-4 with bias weight j: out = 3j-4.
        fill(1, 0, 0);
        for (int j = 0; j < NO; j++) begin
            for (int i = 0; i < NI; i++) mem[WB + j*K + i] = 7'(j - 4);
            mem[WB + j*K + NI] = 7'(j);
        end
        for (int j = 0; j < NO; j++) begin
            ea.o[j] = (3*j - 4 < 0) ? 0 : 3*j - 4;
            eb.o[j] = 3*j - 4;
        end
        ea.am = 9;
        eb.am = 9;
        run(0);

        // All negative: ReLU gives all zero (argmax 0); raw maximum is -1 at row 9.
        fill(1, 0, 0);
        for (int j = 0; j < NO; j++)
            for (int i = 0; i < NI; i++) mem[WB + j*K + i] = 7'(j - 10);
        for (int j = 0; j < NO; j++) begin
            ea.o[j] = 0;
            eb.o[j] = j - 10;
        end
        ea.am = 0;
        eb.am = 9;
        run(0);
        // Restart from DONE reproduces the same results.
        run(0);

        // Soft reset during neuron 4 accumulation.
        fill(1, 1, 0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (100) @(posedge clk);
        #1 chk("mid_busy", 32'(busy_a), 1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        chk("sreset_busy", 32'(busy_a), 0);
        chk("sreset_done", 32'(done_a), 0);
        chk("sreset_out", 32'(out_a == '0 && out_b == '0), 1);
        chk("sreset_argmax", 32'(am_a), 0);
        chk("sreset_addr", 32'(ma_a), 0);
        exp_all(1, 1, 0, 0);
        run(0);

        // Asynchronous reset mid-run takes effect without a clock edge.
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (30) @(posedge clk);
        #2 rst = 1'b1;
        #1 chk("arst_busy", 32'(busy_a), 0);
        chk("arst_out", 32'(out_a == '0), 1);
        @(negedge clk);
        rst = 1'b0;

        chk("sb_a_drained", q_a.size(), 0);
        chk("sb_b_drained", q_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
